// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction memory
// and registers fetched words into the IF/ID register with redirect squashing.
module instr_fetch_stage #(
  parameter int                INSTR_W  = 16,
  parameter int                PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_opcode,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [PC_W-1:0]     pc_r, pc_s;
  logic [PC_W-1:0]     fetch_pc_r, fetch_pc_s;
  logic [PC_W-1:0]     if_pc_r, if_pc_s;
  logic [INSTR_W-1:0]  if_instr_r, if_instr_s;
  logic [INSTR_W-1:0]  hold_data_r, hold_data_s;
  logic [INSTR_W-1:0]  fetch_data_s;
  logic                if_valid_r, if_valid_s;
  logic                held_r, held_s;
  logic                fetch_vld_s;

  // FSM state register (RUN means the word arriving from memory belongs to fetch_pc)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: redirect drops back to IDLE, a stall freezes the current state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          state_s = ST_IDLE;
        end else if (stall) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs / datapath next values.
  // The memory keeps reading pc during a stall, which is one word ahead of
  // fetch_pc, so the word for fetch_pc is parked on the first stall cycle.
  always_comb begin
    fetch_vld_s  = (state_r == ST_RUN);
    fetch_data_s = held_r ? hold_data_r : imem_rdata;
    pc_s         = pc_r;
    fetch_pc_s   = fetch_pc_r;
    if_instr_s   = if_instr_r;
    if_pc_s      = if_pc_r;
    if_valid_s   = if_valid_r;
    held_s       = 1'b0;
    hold_data_s  = hold_data_r;
    if (redirect) begin
      pc_s       = redirect_pc;
      if_instr_s = {INSTR_W{1'b0}};
      if_valid_s = 1'b0;
    end else if (stall) begin
      held_s = 1'b1;
      if (!held_r) begin
        hold_data_s = imem_rdata;
      end else begin
        hold_data_s = hold_data_r;
      end
    end else begin
      pc_s       = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      fetch_pc_s = pc_r;
      if_instr_s = fetch_vld_s ? fetch_data_s : {INSTR_W{1'b0}};
      if_pc_s    = fetch_pc_r;
      if_valid_s = fetch_vld_s;
    end
  end

  // Datapath and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      fetch_pc_r  <= {PC_W{1'b0}};
      if_instr_r  <= {INSTR_W{1'b0}};
      if_pc_r     <= {PC_W{1'b0}};
      if_valid_r  <= 1'b0;
      held_r      <= 1'b0;
      hold_data_r <= {INSTR_W{1'b0}};
    end else begin
      pc_r        <= pc_s;
      fetch_pc_r  <= fetch_pc_s;
      if_instr_r  <= if_instr_s;
      if_pc_r     <= if_pc_s;
      if_valid_r  <= if_valid_s;
      held_r      <= held_s;
      hold_data_r <= hold_data_s;
    end
  end

  assign imem_addr = pc_r;
  assign if_instr  = if_instr_r;
  assign if_opcode = if_instr_r[INSTR_W-1 -: 4];
  assign if_pc     = if_pc_r;
  assign if_valid  = if_valid_r;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, a wrap test
// on a second instance with RESET_PC=0xFE, and random stimulus against a model.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst, stall, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] if_instr;
  logic [3:0]  if_opcode;
  logic [7:0]  if_pc;
  logic        if_valid;

  logic        rst2;
  logic [7:0]  imem_addr2;
  logic [15:0] imem_rdata2;
  logic [15:0] if_instr2;
  logic [3:0]  if_opcode2;
  logic [7:0]  if_pc2;
  logic        if_valid2;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  instr_fetch_stage #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_opcode(if_opcode), .if_pc(if_pc), .if_valid(if_valid)
  );

  instr_fetch_stage #(.INSTR_W(16), .PC_W(8), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(8'h00), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .if_instr(if_instr2), .if_opcode(if_opcode2), .if_pc(if_pc2), .if_valid(if_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction memories
  always @(posedge clk) begin
    imem_rdata  <= mem[imem_addr];
    imem_rdata2 <= mem[imem_addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // apply inputs away from the edge, then let one posedge consume them
  task automatic step(input logic r, input logic s, input logic rd, input logic [7:0] t);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = t;
    @(posedge clk);
    #1;
  endtask

  // ---- behavioural model: delivery order plus a bubble counter ----
  logic [7:0] m_next;
  int         m_bub;
  logic       m_valid;
  logic [7:0] m_pc;

  task automatic model_step(input logic r, input logic s, input logic rd, input logic [7:0] t);
    if (r) begin
      m_valid = 1'b0; m_pc = 8'h00; m_next = 8'h00; m_bub = 1;
    end else if (rd) begin
      m_valid = 1'b0; m_next = t; m_bub = 1;
    end else if (s) begin
      m_valid = m_valid;
    end else if (m_bub > 0) begin
      m_bub--; m_valid = 1'b0;
    end else begin
      m_valid = 1'b1; m_pc = m_next; m_next = m_next + 8'd1;
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [7:0] ep,
                               input logic [15:0] ei, input logic [7:0] ea);
    logic [15:0] tmp;
    tmp = ei;
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, ev});
    chk({tag, ".if_instr"}, {16'd0, if_instr}, {16'd0, ei});
    chk({tag, ".if_opcode"}, {28'd0, if_opcode}, {28'd0, tmp[15:12]});
    chk({tag, ".imem_addr"}, {24'd0, imem_addr}, {24'd0, ea});
    if (ev) chk({tag, ".if_pc"}, {24'd0, if_pc}, {24'd0, ep});
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [7:0]  tgt;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic [15:0] exp_instr;
    logic [7:0]  exp_addr;
  } vec_t;

  vec_t tbl [28];

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; rst2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i < 128) mem[i] = 16'h1000 | 16'(i);
      else         mem[i] = 16'($urandom);
    end
    mem[8'h40] = 16'hA040;
    mem[8'h20] = 16'h7020;

    //           rst   stall redir tgt    valid pc     instr     addr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h01};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 16'h1000, 8'h02};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 16'h1001, 8'h03};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 16'h1002, 8'h04};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 16'h1003, 8'h05};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 16'h1004, 8'h06};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 16'h1005, 8'h07};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 16'h1005, 8'h07};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 16'h1005, 8'h07};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 16'h1005, 8'h07};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 16'h1006, 8'h08};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 16'h1007, 8'h09};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 16'h0000, 8'h40};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h41};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 16'hA040, 8'h42};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 16'h1041, 8'h43};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 16'h0000, 8'h20};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h21};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 16'h7020, 8'h22};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 16'h1021, 8'h23};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h21, 16'h1021, 8'h23};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h00};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h01};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 16'h0000, 8'h10};
    tbl[25] = '{1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 8'h00, 16'h0000, 8'h30};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 8'h31};
    tbl[27] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h30, 16'h1030, 8'h32};

    repeat (2) @(posedge clk);

    // directed vector table
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].tgt);
      check_outputs($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                    tbl[i].exp_instr, tbl[i].exp_addr);
    end

    // PC wrap from RESET_PC=0xFE on the second instance
    begin
      logic [7:0] wrap_exp [4];
      wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
      @(negedge clk); rst2 = 1'b1;
      @(posedge clk); #1;
      chk("wrap.reset_addr", {24'd0, imem_addr2}, 32'h0000_00FE);
      chk("wrap.reset_valid", {31'd0, if_valid2}, 32'd0);
      @(negedge clk); rst2 = 1'b0;
      @(posedge clk); #1;
      chk("wrap.bubble_valid", {31'd0, if_valid2}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chk($sformatf("wrap.valid%0d", k), {31'd0, if_valid2}, 32'd1);
        chk($sformatf("wrap.pc%0d", k), {24'd0, if_pc2}, {24'd0, wrap_exp[k]});
        chk($sformatf("wrap.instr%0d", k), {16'd0, if_instr2}, {16'd0, mem[wrap_exp[k]]});
      end
    end

    // randomized stimulus against the model
    step(1'b1, 1'b0, 1'b0, 8'h00);
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 2000; c++) begin
      logic r, s, rd;
      logic [7:0] t;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      step(r, s, rd, t);
      model_step(r, s, rd, t);
      check_outputs($sformatf("rand%0d", c), m_valid, m_pc,
                    m_valid ? mem[m_pc] : 16'h0000,
                    (m_bub == 0) ? m_next + 8'd1 : m_next);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
